// File: rtl/dma_rd_sched_pkg.sv
// Shared types and helpers for the DMA read scheduler.
package dma_rd_sched_pkg;

  localparam int DEF_ADDR_WIDTH = 64;

  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_ADDR_WIDTH:0]   count_t;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_REQ   = 2'd1,
    CH_DRAIN = 2'd2,
    CH_DONE  = 2'd3
  } ch_state_e;

  // Channel-id width, never narrower than one bit.
  function automatic int ch_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_tag_fifo.sv
// In-order FIFO of channel ids for outstanding memory reads.
module dma_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dma_rd_sched.sv
// Multi-channel DMA read scheduler with round-robin request arbitration.
// Optional per-channel address stride compiled in with DMA_RD_SCHED_STRIDE_EN.
module dma_rd_sched
  import dma_rd_sched_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int NUM_CH          = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_go,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
  input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0] ch_size,
`ifdef DMA_RD_SCHED_STRIDE_EN
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_stride,
`endif
  output logic [NUM_CH-1:0]                ch_done,
  output logic [NUM_CH-1:0]                ch_busy,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic                             mem_waitrequest,
  input  logic                             mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [ch_id_width(NUM_CH)-1:0]   out_ch
);

  localparam int CH_W = ch_id_width(NUM_CH);
  localparam int IF_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [NUM_CH-1:0]     ch_req, issue_vec;
  logic [ADDR_WIDTH-1:0] cur_addr [NUM_CH];
  logic                  req_valid_reg;
  logic [ADDR_WIDTH-1:0] req_addr_reg;
  logic [CH_W-1:0]       req_ch_reg, rr_ptr_reg, grant_idx;
  logic [IF_W-1:0]       inflight_reg, inflight_after;
  logic                  any_req, accept, can_issue;
  logic                  tag_push, tag_pop, tag_full, tag_empty;
  logic [CH_W-1:0]       tag_pop_data;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CH_W-1:0]       out_ch_reg;

  assign accept   = req_valid_reg && !mem_waitrequest;
  assign tag_push = accept && !tag_full;
  assign tag_pop  = mem_rd_valid && !tag_empty;

  // Channel bookkeeping moves when a request is loaded into the request register,
  // so the held-but-unaccepted request already counts against the in-flight limit.
  assign inflight_after = inflight_reg + IF_W'(accept) - IF_W'(tag_pop);
  assign can_issue = any_req && (!req_valid_reg || accept) &&
                     (inflight_after < IF_W'(MAX_OUTSTANDING));

  always_comb begin
    int idx;
    any_req   = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_req && ch_req[idx[CH_W-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = idx[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_reg <= 1'b0;
      req_addr_reg  <= '0;
      req_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
      inflight_reg  <= '0;
    end else begin
      inflight_reg <= inflight_after;
      if (can_issue) begin
        req_valid_reg <= 1'b1;
        req_addr_reg  <= cur_addr[grant_idx];
        req_ch_reg    <= grant_idx;
        rr_ptr_reg    <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
      end else if (accept) begin
        req_valid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_state_e             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, inc;
    logic [ADDR_WIDTH:0]   rem_reg;
    logic [IF_W-1:0]       pend_reg;
    logic                  go_ok, size_zero, pend_dec;

    assign go_ok     = ch_go[gi] && (state_reg == CH_IDLE || state_reg == CH_DONE);
    assign size_zero = (ch_size[gi*(ADDR_WIDTH+1) +: ADDR_WIDTH+1] == '0);
    assign pend_dec  = tag_pop && (tag_pop_data == CH_W'(gi));
    assign issue_vec[gi] = can_issue && (grant_idx == CH_W'(gi));
    assign cur_addr[gi]  = addr_reg;

`ifdef DMA_RD_SCHED_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_reg;
    assign inc = stride_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                       stride_reg <= '0;
      else if (go_ok && !size_zero)  stride_reg <= ch_stride[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
`else
    assign inc = ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= CH_IDLE;
      else     state_reg <= state_next;
    end

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        CH_IDLE, CH_DONE: if (go_ok) state_next = size_zero ? CH_DONE : CH_REQ;
        CH_REQ:   if (issue_vec[gi] && rem_reg == (ADDR_WIDTH+1)'(1)) state_next = CH_DRAIN;
        CH_DRAIN: if (pend_reg == '0) state_next = CH_DONE;
        default:  state_next = CH_IDLE;
      endcase
    end

    assign ch_req[gi]  = (state_reg == CH_REQ);
    assign ch_busy[gi] = (state_reg == CH_REQ) || (state_reg == CH_DRAIN);
    assign ch_done[gi] = (state_reg == CH_DONE);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        addr_reg <= '0;
        rem_reg  <= '0;
        pend_reg <= '0;
      end else begin
        if (go_ok && !size_zero) begin
          addr_reg <= ch_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
          rem_reg  <= ch_size[gi*(ADDR_WIDTH+1) +: ADDR_WIDTH+1];
        end else if (issue_vec[gi]) begin
          addr_reg <= addr_reg + inc;
          rem_reg  <= rem_reg - (ADDR_WIDTH+1)'(1);
        end
        pend_reg <= pend_reg + IF_W'(issue_vec[gi]) - IF_W'(pend_dec);
      end
    end
  end

  dma_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (CH_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (req_ch_reg),
    .pop       (tag_pop),
    .pop_data  (tag_pop_data),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else begin
      out_valid_reg <= tag_pop;
      if (tag_pop) begin
        out_data_reg <= mem_rd_data;
        out_ch_reg   <= tag_pop_data;
      end
    end
  end

  assign mem_rd_en   = req_valid_reg;
  assign mem_rd_addr = req_addr_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_ch      = out_ch_reg;

endmodule

// File: tb/tb_dma_rd_sched.sv
// Directed bench for dma_rd_sched (4 channels, 4 outstanding reads, 32-bit data).
module tb_dma_rd_sched;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int NC = 4;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     ch_go;
  logic [NC*AW-1:0]  ch_addr;
  logic [NC*(AW+1)-1:0] ch_size;
`ifdef DMA_RD_SCHED_STRIDE_EN
  logic [NC*AW-1:0]  ch_stride;
`endif
  logic [NC-1:0]     ch_done, ch_busy;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic              mem_waitrequest;
  logic              mem_rd_valid;
  logic [DW-1:0]     mem_rd_data;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ch;

  int n_checks = 0;
  int n_fail   = 0;
  logic resp_en   = 1'b1;
  logic force_rsp = 1'b0;
  int   en_cnt    = 0;
  logic [AW-1:0] acc_q [$];
  logic [AW-1:0] rsp_q [$];
  logic [DW-1:0] outd_q [$];
  logic [1:0]    outc_q [$];
  logic [AW-1:0] rsp_addr;

  always #5 clk = ~clk;

  dma_rd_sched #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .NUM_CH          (NC),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_go           (ch_go),
    .ch_addr         (ch_addr),
    .ch_size         (ch_size),
`ifdef DMA_RD_SCHED_STRIDE_EN
    .ch_stride       (ch_stride),
`endif
    .ch_done         (ch_done),
    .ch_busy         (ch_busy),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_waitrequest (mem_waitrequest),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ch          (out_ch)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model and monitors: responses only for requests accepted on earlier edges.
  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_q.delete();
        mem_rd_valid = 1'b0;
      end else begin
        if (force_rsp) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = 32'hDEAD_BEEF;
        end else if (resp_en && rsp_q.size() > 0) begin
          rsp_addr     = rsp_q.pop_front();
          mem_rd_valid = 1'b1;
          mem_rd_data  = {16'hD000, rsp_addr[15:0]};
        end else begin
          mem_rd_valid = 1'b0;
        end
        if (mem_rd_en && !mem_waitrequest) begin
          rsp_q.push_back(mem_rd_addr);
          acc_q.push_back(mem_rd_addr);
        end
      end
      if (mem_rd_en) en_cnt++;
      if (out_valid) begin
        outd_q.push_back(out_data);
        outc_q.push_back(out_ch);
      end
    end
  end

  task automatic clear_logs();
    acc_q.delete();
    outd_q.delete();
    outc_q.delete();
    en_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic start(input int ch, input logic [63:0] addr, input logic [64:0] size);
    ch_go[ch] = 1'b1;
    ch_addr[ch*AW +: AW] = addr;
    ch_size[ch*(AW+1) +: AW+1] = size;
    tick();
    ch_go = '0;
  endtask

  task automatic wait_done(input int ch, input int budget, input string tag);
    for (int n = 0; n < budget && !ch_done[ch]; n++) tick();
    check_val(tag, ch_done[ch], 1);
  endtask

  function automatic logic [63:0] acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  function automatic logic [63:0] outc_at(input int i);
    return (i < outc_q.size()) ? 64'(outc_q[i]) : 64'hBAD;
  endfunction

  function automatic logic [63:0] outd_at(input int i);
    return (i < outd_q.size()) ? 64'(outd_q[i]) : 64'hBAD;
  endfunction

  initial begin
    logic [63:0] exp2 [6];
    exp2 = '{64'h200, 64'h300, 64'h201, 64'h301, 64'h202, 64'h302};
    rst = 1'b1;
    ch_go = '0;
    ch_addr = '0;
    ch_size = '0;
    mem_waitrequest = 1'b0;
`ifdef DMA_RD_SCHED_STRIDE_EN
    for (int c = 0; c < NC; c++) ch_stride[c*AW +: AW] = 64'd1;
`endif
    tick();
    tick();
    check_val("rst_mem_rd_en", mem_rd_en, 0);
    check_val("rst_mem_rd_addr", mem_rd_addr, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_ch_done", ch_done, 0);
    check_val("rst_ch_busy", ch_busy, 0);
    rst = 1'b0;
    clear_logs();

    // Single channel, no stalls.
    start(0, 64'h100, 65'd4);
    check_val("t1_busy", ch_busy[0], 1);
    wait_done(0, 60, "t1_done");
    check_val("t1_out_cnt_at_done", outd_q.size(), 4);
    check_val("t1_acc_cnt", acc_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t1_addr%0d", i), acc_at(i), 64'h100 + 64'(i));
      check_val($sformatf("t1_och%0d", i), outc_at(i), 0);
      check_val($sformatf("t1_odat%0d", i), outd_at(i), 64'hD000_0100 + 64'(i));
    end

    // Two channels started together interleave.
    do_reset();
    ch_go[0] = 1'b1; ch_addr[0 +: AW] = 64'h200; ch_size[0 +: AW+1] = 65'd3;
    ch_go[1] = 1'b1; ch_addr[AW +: AW] = 64'h300; ch_size[(AW+1) +: AW+1] = 65'd3;
    tick();
    ch_go = '0;
    check_val("t2_busy", ch_busy, 4'b0011);
    wait_done(1, 80, "t2_done1");
    check_val("t2_done0", ch_done[0], 1);
    check_val("t2_acc_cnt", acc_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("t2_addr%0d", i), acc_at(i), exp2[i]);
      check_val($sformatf("t2_och%0d", i), outc_at(i), 64'(i % 2));
    end

    // Stall on the first request.
    do_reset();
    mem_waitrequest = 1'b1;
    start(2, 64'h40, 65'd2);
    for (int n = 0; n < 10 && !mem_rd_en; n++) tick();
    check_val("t3_en", mem_rd_en, 1);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t3_hold_addr%0d", i), mem_rd_addr, 64'h40);
      tick();
    end
    mem_waitrequest = 1'b0;
    wait_done(2, 40, "t3_done");
    check_val("t3_acc_cnt", acc_q.size(), 2);
    check_val("t3_addr0", acc_at(0), 64'h40);
    check_val("t3_addr1", acc_at(1), 64'h41);
    check_val("t3_out_cnt", outd_q.size(), 2);

    // Outstanding limit with responses withheld.
    do_reset();
    resp_en = 1'b0;
    start(3, 64'h500, 65'd8);
    repeat (20) tick();
    check_val("t4_acc_limited", acc_q.size(), MO);
    check_val("t4_en_low", mem_rd_en, 0);
    check_val("t4_busy", ch_busy[3], 1);
    resp_en = 1'b1;
    wait_done(3, 100, "t4_done");
    check_val("t4_acc_cnt", acc_q.size(), 8);
    check_val("t4_last_addr", acc_at(7), 64'h507);
    check_val("t4_out_cnt", outd_q.size(), 8);
    check_val("t4_last_ch", outc_at(7), 3);
    check_val("t4_last_dat", outd_at(7), 64'hD000_0507);

    // Zero-size transfer.
    do_reset();
    start(1, 64'h700, 65'd0);
    check_val("t5_done_next", ch_done, 4'b0010);
    check_val("t5_busy", ch_busy[1], 0);
    repeat (5) tick();
    check_val("t5_no_en", en_cnt, 0);

    // Reset mid-transfer, then a stray response.
    do_reset();
    resp_en = 1'b0;
    start(0, 64'h600, 65'd8);
    repeat (10) tick();
    check_val("t6_inflight", acc_q.size(), MO);
    rst = 1'b1;
    #1;
    check_val("t6_rst_en", mem_rd_en, 0);
    check_val("t6_rst_addr", mem_rd_addr, 0);
    check_val("t6_rst_busy", ch_busy, 0);
    check_val("t6_rst_done", ch_done, 0);
    check_val("t6_rst_oval", out_valid, 0);
    tick();
    rst = 1'b0;
    clear_logs();
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    repeat (3) tick();
    check_val("t6_drop_cnt", outd_q.size(), 0);
    check_val("t6_no_en", en_cnt, 0);
    resp_en = 1'b1;
    start(0, 64'h10, 65'd1);
    wait_done(0, 30, "t6_after_done");
    check_val("t6_after_cnt", outd_q.size(), 1);
    check_val("t6_after_dat", outd_at(0), 64'hD000_0010);

`ifdef DMA_RD_SCHED_STRIDE_EN
    // Stride with address wrap.
    do_reset();
    ch_stride[0 +: AW] = 64'd2;
    start(0, 64'hFFFF_FFFF_FFFF_FFFE, 65'd3);
    wait_done(0, 40, "t7_done");
    check_val("t7_acc_cnt", acc_q.size(), 3);
    check_val("t7_addr0", acc_at(0), 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("t7_addr1", acc_at(1), 64'h0);
    check_val("t7_addr2", acc_at(2), 64'h2);
    ch_stride[0 +: AW] = 64'd1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
